load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the byte-wide, big-endian data memory. Takes one 24-bit
//  load/store request via a valid/ready handshake. Sequences it as three byte beats
//  on the memory port (MSB at base address). Returns a one-cycle response.
//  Sits between the execute stage and the data memory.
// PARAMETERS
//  ADDR_W      24   address width (request and memory port)
//  MEM_DEPTH   128  memory size in bytes; used for the range check
// PORTS
//  Clock         in   1       system clock, rising edge
//  ResetN        in   1       asynchronous, active-low reset
//  ReqValid      in   1       request present
//  ReqReady      out  1       request accepted when ReqValid&ReqReady at posedge
//  ReqWrite      in   1       1=store, 0=load
//  ReqAddress    in   ADDR_W  byte address of word MSB
//  ReqWriteData  in   24      store data
//  RespValid     out  1       one-cycle pulse: load data valid / store complete
//  RespReadData  out  24      assembled load word
//  RespError     out  1       qualifies RespValid: request out of range
//  MemAddress    out  ADDR_W  byte address to memory
//  MemWriteData  out  8       byte to write
//  MemWrite      out  1       byte write strobe, sampled by memory at posedge
//  MemRead       out  1       byte read strobe
//  MemReadData   in   8       combinational read data for MemAddress
// BEHAVIOUR
//  Reset (async, ResetN=0):
//   - state=IDLE
//   - RespValid, RespError, MemWrite, MemRead = 0
//   - RespReadData=0, MemAddress=0, MemWriteData=0
//   - ReqReady=1 once ResetN=1
//  FSM states: IDLE, BYTE0, BYTE1, BYTE2, RESP.
//  IDLE:
//   - ReqReady=1; ReqReady=0 in all other states (combinational from state)
//   - On accept: latch address, data and ReqWrite
//   - Go to BYTE0, or to RESP with error when ReqAddress > MEM_DEPTH-3
//   - Compare before any add, so no 24-bit overflow
//  BYTEn (n=0..2):
//   - MemAddress = base+n
//   - Store: MemWrite=1, MemWriteData = data[23-8n -: 8]
//   - Load: MemRead=1; MemReadData captured at posedge into lane [23-8n -: 8]
//   - Strobes are registered outputs: high exactly during BYTE0..BYTE2, never
//     both high, low in IDLE and RESP
//  RESP:
//   - RespValid=1 for exactly one cycle, then IDLE
//   - RespReadData updates only on a load response; it holds between responses
//     and is not changed by a store
//  Latency: accept edge to RespValid high = 4 cycles (3 beats + RESP).
//   Error response = 1 cycle (RESP directly).
//   Throughput: one request per 5 cycles; no accept during RESP.
//  Error path:
//   - No memory strobes at all
//   - RespError=1 with RespValid; RespReadData unchanged
//  RespError=0 whenever RespValid=0.
//  ReqAddress/ReqWriteData/ReqWrite are don't-care after accept; changes mid-op
//   have no effect.
//  Reset mid-operation: aborts immediately, no response. A store may have written
//   0-2 bytes; software must retry.
//  ReqValid held with ReqReady=0: request is not lost; it is accepted on return to IDLE.
// STRUCTURE
//  Shared package lsu_pkg: state encoding (3-bit localparams), BYTES_PER_WORD=3,
//   byte-lane select function lane(word,n).
//  Single module; no sub-module. Lane mux and capture are small enough to stay inline.
// TESTING
//  1 Store 0xA1B2C3 @0x10
//    -> MemWrite beats addr 0x10/0x11/0x12, data 0xA1/0xB2/0xC3
//    -> RespValid 4 cycles after accept, RespError=0
//  2 Load @0x10, memory bytes 0xA1,0xB2,0xC3
//    -> RespReadData=0xA1B2C3, MemRead high 3 cycles, MemWrite never high
//  3 Load @0x7E (MEM_DEPTH=128)
//    -> RespError=1 one cycle after accept, no strobes, RespReadData unchanged
//  4 Load @0x7D
//    -> legal: beats 0x7D..0x7F, RespError=0
//  5 ReqValid held high with back-to-back store then load @0x20
//    -> second accept in first IDLE cycle after RESP, ReqReady low for 4 cycles between
//  6 ResetN low during BYTE1 of a store
//    -> strobes drop same cycle, no RespValid, ReqReady=1 after release

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// State encoding, word geometry and byte-lane selection.
package lsu_pkg;

    localparam int BYTES_PER_WORD = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BYTE0 = 3'd1;
    localparam logic [2:0] S_BYTE1 = 3'd2;
    localparam logic [2:0] S_BYTE2 = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        BYTE0 = S_BYTE0,
        BYTE1 = S_BYTE1,
        BYTE2 = S_BYTE2,
        RESP  = S_RESP
    } lsu_state_t;

    // Byte n of a big-endian word (n=0 is the MSB).
    function automatic logic [7:0] lane(
        input logic [23:0] word,
        input logic [1:0]  n
    );
        logic [4:0] top;
        top = 5'd23 - {n, 3'b000};
        return word[top -: 8];
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: one 24-bit request as three big-endian byte beats.
// Ports: Clock/ResetN, Req* handshake, Resp* pulse, Mem* byte port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int MEM_DEPTH = 128
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddress,
    input  logic [23:0]       ReqWriteData,
    output logic              RespValid,
    output logic [23:0]       RespReadData,
    output logic              RespError,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [7:0]        MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [7:0]        MemReadData
);

    // Highest legal base address; compared before any add.
    localparam logic [ADDR_W-1:0] LAST =
        ADDR_W'(MEM_DEPTH - BYTES_PER_WORD);

    lsu_state_t        state;
    logic [ADDR_W-1:0] base;
    logic [23:0]       wdata;
    logic              write;
    logic [15:0]       rbuf;

    // Not ready while held in reset.
    assign ReqReady = ResetN && (state == IDLE);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state        <= IDLE;
            base         <= '0;
            wdata        <= '0;
            write        <= 1'b0;
            rbuf         <= '0;
            RespValid    <= 1'b0;
            RespError    <= 1'b0;
            RespReadData <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
        end else begin
            RespValid <= 1'b0;
            RespError <= 1'b0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        base  <= ReqAddress;
                        wdata <= ReqWriteData;
                        write <= ReqWrite;
                        if (ReqAddress > LAST) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            RespError <= 1'b1;
                        end else begin
                            state        <= BYTE0;
                            MemAddress   <= ReqAddress;
                            MemWriteData <= lane(ReqWriteData, 2'd0);
                            MemWrite     <= ReqWrite;
                            MemRead      <= !ReqWrite;
                        end
                    end
                end
                BYTE0: begin
                    if (!write) rbuf[15:8] <= MemReadData;
                    state        <= BYTE1;
                    MemAddress   <= base + ADDR_W'(1);
                    MemWriteData <= lane(wdata, 2'd1);
                    MemWrite     <= write;
                    MemRead      <= !write;
                end
                BYTE1: begin
                    if (!write) rbuf[7:0] <= MemReadData;
                    state        <= BYTE2;
                    MemAddress   <= base + ADDR_W'(2);
                    MemWriteData <= lane(wdata, 2'd2);
                    MemWrite     <= write;
                    MemRead      <= !write;
                end
                BYTE2: begin
                    // Publish the whole word at once so it holds
                    // between load responses.
                    if (!write) RespReadData <= {rbuf, MemReadData};
                    state     <= RESP;
                    RespValid <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
